// File: rtl/quiz_round_ctrl.sv
// Quiz round sequencer: round FSM, per-problem countdown, score/lives and answer commit gating.
// Optional build macro QUIZ_STREAK_BONUS_EN: a correct answer on a streak of 2 or more adds 2 points.
//
// state   | meaning
// IDLE    | powered up, waiting for i_start
// PLAY    | problem shown, countdown running, waiting for an answer or timeout
// COMMIT  | answer committed, waiting for the scroll animation to finish
// OVER    | no lives left, counters frozen, waiting for i_start
module quiz_round_ctrl #(
  parameter int FRAMES_PER_SEC = 60,
  parameter int TIME_LIMIT_SEC = 10,
  parameter int START_LIVES    = 3
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_frame_tick,
  input  logic       i_digit_valid,
  input  logic [3:0] i_digit,
  input  logic [3:0] i_expected,
  input  logic       i_scroll_busy,
  output logic       o_digit_identified,
  output logic [3:0] o_digit_answered,
  output logic       o_clear_canvas,
  output logic [7:0] o_score,
  output logic [1:0] o_lives,
  output logic [7:0] o_time_left,
  output logic [1:0] o_state,
  output logic       o_game_over
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PLAY   = 2'd1,
    ST_COMMIT = 2'd2,
    ST_OVER   = 2'd3
  } state_t;

  localparam int SUB_W = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
  localparam logic [SUB_W-1:0] SUB_LAST     = SUB_W'(FRAMES_PER_SEC - 1);
  localparam logic [7:0]       TIME_RELOAD  = 8'(TIME_LIMIT_SEC);
  localparam logic [1:0]       LIVES_RELOAD = 2'(START_LIVES);
  localparam logic [3:0]       ANS_TIMEOUT  = 4'hF;

  state_t           state_q, state_d;
  logic [SUB_W-1:0] sub_q, sub_d;
  logic [7:0]       time_q, time_d;
  logic [7:0]       score_q, score_d;
  logic [1:0]       lives_q, lives_d;
  logic [7:0]       streak_q, streak_d;
  logic [3:0]       answered_q, answered_d;
  logic             ident_q, ident_d;
  logic             clear_q, clear_d;
  logic             over_q, over_d;
  logic             seen_busy_q, seen_busy_d;
  logic [1:0]       wd_q, wd_d;

  logic       commit;
  logic       timeout;
  logic       correct;
  logic       round_done;
  logic [3:0] answer;
  logic [1:0] inc;
  logic [8:0] score_sum;

  always_comb begin
    state_d     = state_q;
    sub_d       = sub_q;
    time_d      = time_q;
    score_d     = score_q;
    lives_d     = lives_q;
    streak_d    = streak_q;
    answered_d  = answered_q;
    ident_d     = 1'b0;
    clear_d     = 1'b0;
    seen_busy_d = seen_busy_q;
    wd_d        = wd_q;
    commit      = 1'b0;
    timeout     = 1'b0;
    correct     = 1'b0;
    round_done  = 1'b0;
    answer      = ANS_TIMEOUT;
    inc         = 2'd1;
    score_sum   = 9'd0;

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (i_start) begin
          score_d  = 8'd0;
          lives_d  = LIVES_RELOAD;
          streak_d = 8'd0;
          time_d   = TIME_RELOAD;
          sub_d    = '0;
          state_d  = ST_PLAY;
        end
      end

      ST_PLAY: begin
        // A real answer beats a timeout that expires in the same cycle.
        if (i_digit_valid && !i_scroll_busy) begin
          commit = 1'b1;
          answer = i_digit;
        end else if (time_q == 8'd0) begin
          commit  = 1'b1;
          timeout = 1'b1;
        end else if (i_frame_tick) begin
          if (sub_q == SUB_LAST) begin
            sub_d  = '0;
            time_d = time_q - 8'd1;
          end else begin
            sub_d = sub_q + 1'b1;
          end
        end
      end

      ST_COMMIT: begin
        if (i_scroll_busy) seen_busy_d = 1'b1;
        if (wd_q != 2'd3) wd_d = wd_q + 2'd1;
        // Scroller that never raises busy must not stall the game.
        round_done = !i_scroll_busy && (seen_busy_q || (wd_q == 2'd3));
        if (round_done) begin
          clear_d = 1'b1;
          if (lives_q == 2'd0) begin
            state_d = ST_OVER;
          end else begin
            time_d  = TIME_RELOAD;
            sub_d   = '0;
            state_d = ST_PLAY;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (commit) begin
      ident_d     = 1'b1;
      answered_d  = answer;
      state_d     = ST_COMMIT;
      seen_busy_d = 1'b0;
      wd_d        = 2'd0;
      correct     = !timeout && (answer == i_expected);
`ifdef QUIZ_STREAK_BONUS_EN
      inc = (streak_q >= 8'd2) ? 2'd2 : 2'd1;
`else
      inc = 2'd1;
`endif
      if (correct) begin
        score_sum = {1'b0, score_q} + {7'd0, inc};
        score_d   = score_sum[8] ? 8'hFF : score_sum[7:0];
        streak_d  = (streak_q == 8'hFF) ? streak_q : streak_q + 8'd1;
      end else begin
        lives_d  = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
        streak_d = 8'd0;
      end
    end

    over_d = (state_d == ST_OVER);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      sub_q       <= '0;
      time_q      <= TIME_RELOAD;
      score_q     <= 8'd0;
      lives_q     <= LIVES_RELOAD;
      streak_q    <= 8'd0;
      answered_q  <= ANS_TIMEOUT;
      ident_q     <= 1'b0;
      clear_q     <= 1'b0;
      over_q      <= 1'b0;
      seen_busy_q <= 1'b0;
      wd_q        <= 2'd0;
    end else begin
      state_q     <= state_d;
      sub_q       <= sub_d;
      time_q      <= time_d;
      score_q     <= score_d;
      lives_q     <= lives_d;
      streak_q    <= streak_d;
      answered_q  <= answered_d;
      ident_q     <= ident_d;
      clear_q     <= clear_d;
      over_q      <= over_d;
      seen_busy_q <= seen_busy_d;
      wd_q        <= wd_d;
    end
  end

  assign o_digit_identified = ident_q;
  assign o_digit_answered   = answered_q;
  assign o_clear_canvas     = clear_q;
  assign o_score            = score_q;
  assign o_lives            = lives_q;
  assign o_time_left        = time_q;
  assign o_state            = state_q;
  assign o_game_over        = over_q;

endmodule

// File: tb/tb_quiz_round_ctrl.sv
// Scoreboard bench for quiz_round_ctrl: commits are predicted at stimulus time and checked on the pulse.
module tb_quiz_round_ctrl;

  localparam int FPS = 60;
  localparam int TL  = 10;
  localparam int SL  = 3;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_start;
  logic       i_frame_tick;
  logic       i_digit_valid;
  logic [3:0] i_digit;
  logic [3:0] i_expected;
  logic       i_scroll_busy;
  logic       o_digit_identified;
  logic [3:0] o_digit_answered;
  logic       o_clear_canvas;
  logic [7:0] o_score;
  logic [1:0] o_lives;
  logic [7:0] o_time_left;
  logic [1:0] o_state;
  logic       o_game_over;

  quiz_round_ctrl #(
    .FRAMES_PER_SEC(FPS),
    .TIME_LIMIT_SEC(TL),
    .START_LIVES   (SL)
  ) dut (
    .i_clk             (i_clk),
    .i_rst_n           (i_rst_n),
    .i_start           (i_start),
    .i_frame_tick      (i_frame_tick),
    .i_digit_valid     (i_digit_valid),
    .i_digit           (i_digit),
    .i_expected        (i_expected),
    .i_scroll_busy     (i_scroll_busy),
    .o_digit_identified(o_digit_identified),
    .o_digit_answered  (o_digit_answered),
    .o_clear_canvas    (o_clear_canvas),
    .o_score           (o_score),
    .o_lives           (o_lives),
    .o_time_left       (o_time_left),
    .o_state           (o_state),
    .o_game_over       (o_game_over)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [3:0] ans;
    logic [7:0] score;
    logic [1:0] lives;
  } exp_t;

  exp_t sbq[$];
  int   vectors = 0;
  int   errors  = 0;
  int   m_score, m_lives, m_streak;
  logic prev_id = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic model_reset();
    m_score  = 0;
    m_lives  = SL;
    m_streak = 0;
  endtask

  task automatic model_commit(input logic [3:0] ans, input logic [3:0] expv, input bit to);
    exp_t e;
    int   inc;
    inc = 1;
    if (!to && ans == expv) begin
`ifdef QUIZ_STREAK_BONUS_EN
      if (m_streak >= 2) inc = 2;
`endif
      m_score  = (m_score + inc > 255) ? 255 : m_score + inc;
      m_streak = (m_streak < 255) ? m_streak + 1 : 255;
    end else begin
      if (m_lives > 0) m_lives--;
      m_streak = 0;
    end
    e.ans   = ans;
    e.score = 8'(m_score);
    e.lives = 2'(m_lives);
    sbq.push_back(e);
  endtask

  task automatic start_game();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    model_reset();
  endtask

  task automatic answer(input logic [3:0] d, input logic [3:0] expv);
    i_digit_valid = 1'b1;
    i_digit       = d;
    i_expected    = expv;
    model_commit(d, expv, 1'b0);
    step();
    i_digit_valid = 1'b0;
  endtask

  // Called one step after the commit edge; busy_cycles=0 exercises the watchdog.
  task automatic finish_round(input int busy_cycles, input logic [1:0] exp_state);
    int idx;
    int exp_idx;
    idx = -1;
    exp_idx = (busy_cycles > 0) ? 1 : 4;
    if (busy_cycles > 0) begin
      i_scroll_busy = 1'b1;
      for (int i = 0; i < busy_cycles; i++) begin
        i_digit_valid = (i == 10);
        step();
      end
      i_digit_valid = 1'b0;
      i_scroll_busy = 1'b0;
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge i_clk);
      if (o_clear_canvas) begin
        idx = i;
        break;
      end
    end
    chk("clear_cycle", idx, exp_idx);
    chk("state_after_round", o_state, exp_state);
    chk("game_over_after_round", o_game_over, exp_state == 2'd3);
    if (exp_state == 2'd1) chk("time_reload", o_time_left, TL);
    @(negedge i_clk);
    chk("clear_width", o_clear_canvas, 0);
  endtask

  always @(negedge i_clk) begin
    if (o_digit_identified) begin
      chk("ident_width", prev_id, 0);
      if (sbq.size() == 0) begin
        chk("sb_unexpected_commit", o_digit_identified, 0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("commit_answer", o_digit_answered, e.ans);
        chk("commit_score", o_score, e.score);
        chk("commit_lives", o_lives, e.lives);
        chk("commit_state", o_state, 2);
      end
    end
    prev_id = o_digit_identified;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    i_rst_n = 1'b0;
    i_start = 1'b0;
    i_frame_tick = 1'b0;
    i_digit_valid = 1'b0;
    i_digit = 4'd0;
    i_expected = 4'd0;
    i_scroll_busy = 1'b0;
    model_reset();
    repeat (3) step();
    chk("rst_state", o_state, 0);
    chk("rst_answered", o_digit_answered, 4'hF);
    chk("rst_score", o_score, 0);
    chk("rst_lives", o_lives, SL);
    chk("rst_time", o_time_left, TL);
    chk("rst_pulses", {o_digit_identified, o_clear_canvas, o_game_over}, 0);
    i_rst_n = 1'b1;
    step();

    // IDLE ignores classifier and frame ticks
    i_digit_valid = 1'b1;
    i_frame_tick  = 1'b1;
    repeat (3) step();
    i_digit_valid = 1'b0;
    i_frame_tick  = 1'b0;
    chk("idle_time", o_time_left, TL);
    chk("idle_state", o_state, 0);

    // Correct answer, then a 50-cycle scroll with a stray valid inside it
    start_game();
    chk("start_state", o_state, 1);
    chk("start_score", o_score, 0);
    answer(4'd7, 4'd7);
    finish_round(50, 2'd1);
    chk("answered_hold", o_digit_answered, 7);

    // Countdown to zero, then timeout commit of 4'hF
    i_expected = 4'd5;
    i_frame_tick = 1'b1;
    for (int s = 0; s < TL; s++) begin
      repeat (FPS) step();
      chk("countdown", o_time_left, TL - 1 - s);
    end
    i_frame_tick = 1'b0;
    model_commit(4'hF, i_expected, 1'b1);
    step();
    finish_round(0, 2'd1);

    // Valid arrives in the same cycle the timer reads zero: valid wins
    i_frame_tick = 1'b1;
    repeat (FPS * TL) step();
    i_frame_tick = 1'b0;
    chk("time_zero", o_time_left, 0);
    answer(4'd4, 4'd4);
    finish_round(0, 2'd1);

    // Valid while the scroller is still busy in PLAY is dropped
    i_scroll_busy = 1'b1;
    i_digit_valid = 1'b1;
    i_digit = 4'd5;
    i_expected = 4'd5;
    step();
    i_digit_valid = 1'b0;
    @(negedge i_clk);
    chk("busy_drop_ident", o_digit_identified, 0);
    chk("busy_drop_state", o_state, 1);
    i_scroll_busy = 1'b0;

    // Start in PLAY is ignored
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    chk("play_start_score", o_score, m_score);
    chk("play_start_lives", o_lives, m_lives);

    // Lose the remaining two lives -> OVER
    answer(4'd1, 4'd2);
    finish_round(0, 2'd1);
    answer(4'd0, 4'd9);
    finish_round(0, 2'd2 + 2'd1);
    i_digit_valid = 1'b1;
    i_frame_tick  = 1'b1;
    repeat (4) step();
    i_digit_valid = 1'b0;
    i_frame_tick  = 1'b0;
    chk("over_state", o_state, 3);
    chk("over_lives", o_lives, 0);
    chk("over_score", o_score, m_score);
    chk("over_time_frozen", o_time_left, TL);

    // Restart and lose all three lives
    start_game();
    chk("restart_state", o_state, 1);
    chk("restart_score", o_score, 0);
    chk("restart_lives", o_lives, SL);
    answer(4'd3, 4'd8);
    finish_round(5, 2'd1);
    answer(4'd6, 4'd2);
    finish_round(0, 2'd1);
    answer(4'd9, 4'd0);
    finish_round(0, 2'd3);
    chk("over_flag", o_game_over, 1);

    // Score saturation
    start_game();
    for (int k = 0; k < 258; k++) begin
      answer(4'(k % 10), 4'(k % 10));
      finish_round(0, 2'd1);
    end
    chk("score_saturated", o_score, 255);

    // Asynchronous reset in the middle of COMMIT
    i_digit_valid = 1'b1;
    i_digit = 4'd3;
    i_expected = 4'd3;
    step();
    i_digit_valid = 1'b0;
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("midrst_state", o_state, 0);
    chk("midrst_answered", o_digit_answered, 4'hF);
    chk("midrst_score", o_score, 0);
    chk("midrst_lives", o_lives, SL);
    chk("midrst_time", o_time_left, TL);
    chk("midrst_pulses", {o_digit_identified, o_clear_canvas, o_game_over}, 0);
    step();
    i_rst_n = 1'b1;
    repeat (6) step();
    chk("midrst_idle", o_state, 0);
    chk("sb_drain", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
